// File: rtl/proc_step_ctrl_pkg.sv
// Shared definitions for the processor run/step controller: FSM state
// encodings, MODE width, debounce window default and the cycle-counter helper.
package proc_step_ctrl_pkg;

  localparam int          MODE_W        = 2;
  localparam int          CNT_W         = 16;
  localparam logic [15:0] DB_CYCLES_DEF = 16'd50000;
  localparam logic [CNT_W-1:0] CNT_MAX  = 16'hFFFF;

  typedef enum logic [MODE_W-1:0] {
    ST_HALT      = 2'b00,
    ST_RUN       = 2'b01,
    ST_STEP_WAIT = 2'b10,
    ST_STOPPED   = 2'b11
  } state_t;

  // Saturating increment: the count sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/step_debounce.sv
// Debouncer for the (already synchronized) single-step button. The stable
// level follows the input only after it has disagreed for DB_CYCLES
// consecutive cycles; a one-cycle registered pulse marks each stable 0->1.
module step_debounce
  import proc_step_ctrl_pkg::*;
#(
  parameter logic [15:0] DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_sync,
  output logic step_req
);

  logic [15:0] cnt_q, cnt_d;
  logic        stable_q, stable_d;
  logic        pulse_q, pulse_d;

  // Count consecutive disagreement cycles; any agreement restarts the window.
  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    pulse_d  = 1'b0;
    if (btn_sync != stable_q) begin
      if (cnt_q == DB_CYCLES - 16'd1) begin
        stable_d = btn_sync;
        pulse_d  = btn_sync;
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
      pulse_q  <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      pulse_q  <= pulse_d;
    end
  end

  assign step_req = pulse_q;

endmodule

// File: rtl/proc_step_ctrl.sv
// Processor run/halt/single-step controller. Synchronizes the divided clock
// and the operator controls into CLK_50, detects divided-clock rising edges
// and issues one-cycle CPU_EN pulses according to the run/step FSM.
// Optional feature: define PROC_STEP_CTRL_CYCLE_CNT_EN to build the
// saturating CPU_EN pulse counter; otherwise CYCLE_CNT reads as zero.
module proc_step_ctrl
  import proc_step_ctrl_pkg::*;
#(
  parameter logic [15:0] DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic              CLK_50,
  input  logic              RST,
  input  logic              VAR_CLK,
  input  logic              RUN_SW,
  input  logic              STEP_BTN,
  input  logic              HALT_REQ,
  output logic              CPU_EN,
  output logic [MODE_W-1:0] MODE,
  output logic [CNT_W-1:0]  CYCLE_CNT
);

  logic   var_s1_q, var_s2_q, var_prev_q;
  logic   run_s1_q, run_s2_q;
  logic   step_s1_q, step_s2_q;
  logic   var_edge;
  logic   step_req;
  state_t state_q, state_d;
  logic   cpu_en_q, cpu_en_d;

  // Two-flop synchronizers plus the previous-sample flop for edge detection.
  always_ff @(posedge CLK_50 or posedge RST) begin
    if (RST) begin
      var_s1_q   <= 1'b0;
      var_s2_q   <= 1'b0;
      var_prev_q <= 1'b0;
      run_s1_q   <= 1'b0;
      run_s2_q   <= 1'b0;
      step_s1_q  <= 1'b0;
      step_s2_q  <= 1'b0;
    end else begin
      var_s1_q   <= VAR_CLK;
      var_s2_q   <= var_s1_q;
      var_prev_q <= var_s2_q;
      run_s1_q   <= RUN_SW;
      run_s2_q   <= run_s1_q;
      step_s1_q  <= STEP_BTN;
      step_s2_q  <= step_s1_q;
    end
  end

  assign var_edge = var_s2_q & ~var_prev_q;

  step_debounce #(
    .DB_CYCLES (DB_CYCLES)
  ) u_step_db (
    .clk      (CLK_50),
    .rst      (RST),
    .btn_sync (step_s2_q),
    .step_req (step_req)
  );

  // Next state and next CPU_EN; HALT_REQ overrides edge, step and RUN_SW.
  always_comb begin
    state_d  = state_q;
    cpu_en_d = 1'b0;
    unique case (state_q)
      ST_HALT: begin
        if (run_s2_q)      state_d = ST_RUN;
        else if (step_req) state_d = ST_STEP_WAIT;
      end
      ST_RUN: begin
        if (HALT_REQ) begin
          state_d = ST_STOPPED;
        end else begin
          cpu_en_d = var_edge;
          if (!run_s2_q) state_d = ST_HALT;
        end
      end
      ST_STEP_WAIT: begin
        if (HALT_REQ) begin
          state_d = ST_STOPPED;
        end else if (var_edge) begin
          cpu_en_d = 1'b1;
          state_d  = ST_HALT;
        end
      end
      ST_STOPPED: begin
        if (!run_s2_q && !HALT_REQ) state_d = ST_HALT;
      end
      default: state_d = ST_HALT;
    endcase
  end

  // FSM state and registered CPU_EN.
  always_ff @(posedge CLK_50 or posedge RST) begin
    if (RST) begin
      state_q  <= ST_HALT;
      cpu_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cpu_en_q <= cpu_en_d;
    end
  end

  assign CPU_EN = cpu_en_q;
  assign MODE   = state_q;

`ifdef PROC_STEP_CTRL_CYCLE_CNT_EN
  logic [CNT_W-1:0] cyc_cnt_q, cyc_cnt_d;

  // Count issued CPU_EN pulses, holding at all-ones.
  always_comb begin
    cyc_cnt_d = cpu_en_q ? sat_inc(cyc_cnt_q) : cyc_cnt_q;
  end

  // Cycle counter register.
  always_ff @(posedge CLK_50 or posedge RST) begin
    if (RST) cyc_cnt_q <= '0;
    else     cyc_cnt_q <= cyc_cnt_d;
  end

  assign CYCLE_CNT = cyc_cnt_q;
`else
  assign CYCLE_CNT = '0;
`endif

endmodule
